fe_bf2_seq: RTL and testbench

Frame sequencer for the radix-2 SDF front-end chain built from `fe_bf2_fifo` stages. It sits between the sample source and the butterfly pipeline, carrying two complex samples per beat. It frames the incoming beat stream, produces the per-beat index that drives butterfly and twiddle selection, and validates start-of-frame alignment. After the stream stops, it injects dummy beats to drain the last frame held in the stage FIFOs.

---
 rtl/fe_bf2_seq_pkg.sv | 21 ++
 rtl/fe_bf2_seq_gap.sv | 35 +++
 rtl/fe_bf2_seq.sv | 147 ++++++++++++++
 tb/tb_fe_bf2_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fe_bf2_seq_pkg.sv
// Shared types and helpers for the SDF front-end frame sequencer.
// Holds the sequencer state encoding, the beats-per-frame helper and the
// gap counter width.
package fe_bf2_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } fe_bf2_seq_state_t;

    // Width of the idle-gap counter; TMO must fit in it.
    localparam int NBW_GAP = 8;

    // Beats per frame: two complex samples travel per beat.
    function automatic int npair(input int nfft_log2);
        return 1 << (nfft_log2 - 1);
    endfunction

endpackage

// File: rtl/fe_bf2_seq_gap.sv
// Saturating idle-gap counter for the frame sequencer flush timeout.
// Latency: count is registered; tc is combinational ("next count reaches TMO").
// Backpressure: none; clr wins over inc.
// Ports: clk, rst_async_n, clr (restart from 0), inc (one idle cycle), tc (terminal count).
module fe_bf2_seq_gap
    import fe_bf2_seq_pkg::*;
#(
    parameter int TMO = 16
) (
    input  logic clk,
    input  logic rst_async_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [NBW_GAP-1:0] TMO_V = NBW_GAP'(TMO);

    logic [NBW_GAP-1:0] gap_q;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            gap_q <= '0;
        end else if (clr) begin
            gap_q <= '0;
        end else if (inc && (gap_q != TMO_V)) begin
            gap_q <= gap_q + NBW_GAP'(1);
        end
    end

    // Flag the cycle whose increment would land on TMO, so the caller can
    // switch state on the same edge the count saturates.
    assign tc = inc & ~clr & (gap_q >= (TMO_V - NBW_GAP'(1)));

endmodule

// File: rtl/fe_bf2_seq.sv
// Frame sequencer for the radix-2 SDF chain: frames beats, emits per-beat index, flushes the tail.
// Latency: 1 cycle from accepted beat to registered outputs; o_ready decoded from state only.
// Backpressure: o_ready low only while flush beats are injected (FE_BF2_SEQ_FLUSH_EN builds flush).
// Ports: clk, rst_async_n, i_enable/i_valid/i_sof in; o_ready, o_valid_dp, o_flush, o_count,
//        o_sof, o_eof, o_busy, o_err_sof, o_err_sync out.
module fe_bf2_seq
    import fe_bf2_seq_pkg::*;
#(
    parameter int NFFT_LOG2 = 6,
    parameter int TMO       = 16
) (
    input  logic                 clk,
    input  logic                 rst_async_n,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_sof,
    output logic                 o_ready,
    output logic                 o_valid_dp,
    output logic                 o_flush,
    output logic [NFFT_LOG2-2:0] o_count,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_busy,
    output logic                 o_err_sof,
    output logic                 o_err_sync
);

    localparam int NBC   = NFFT_LOG2 - 1;
    localparam int NPAIR = npair(NFFT_LOG2);
    localparam logic [NBC-1:0] IDX_LAST = NBC'(NPAIR - 1);
    localparam logic [NBC-1:0] IDX_ONE  = NBC'(1);

    fe_bf2_seq_state_t state_q;
    logic [NBC-1:0]    idx_q;      // index of the next beat to be emitted
    logic              beat;

    assign beat = i_valid & o_ready;

`ifdef FE_BF2_SEQ_FLUSH_EN
    logic gap_tc;

    assign o_ready = (state_q != ST_FLUSH);

    fe_bf2_seq_gap #(
        .TMO (TMO)
    ) u_gap (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .clr         (beat | (state_q != ST_WAIT)),
        .inc         ((state_q == ST_WAIT) & ~beat),
        .tc          (gap_tc)
    );
`else
    assign o_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            o_valid_dp <= 1'b0;
            o_flush    <= 1'b0;
            o_count    <= '0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_busy     <= 1'b0;
            o_err_sof  <= 1'b0;
            o_err_sync <= 1'b0;
        end else begin
            // Per-beat flags are single-cycle unless set below.
            o_valid_dp <= 1'b0;
            o_flush    <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_err_sof  <= 1'b0;
            o_err_sync <= 1'b0;

            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (beat) begin
                        if (i_sof && i_enable) begin
                            state_q    <= ST_RUN;
                            o_busy     <= 1'b1;
                            o_valid_dp <= 1'b1;
                            o_sof      <= 1'b1;
                            o_count    <= '0;
                            idx_q      <= IDX_ONE;
                        end else if (!i_sof) begin
                            o_err_sync <= 1'b1;
                        end
                        // SOF with i_enable low is dropped without error.
                    end
`ifdef FE_BF2_SEQ_FLUSH_EN
                    else if (gap_tc) begin
                        // idx_q wrapped to 0 at end of frame, so flush starts at index 0.
                        state_q <= ST_FLUSH;
                    end
`endif
                end

                ST_RUN: begin
                    if (beat) begin
                        o_valid_dp <= 1'b1;
                        if (i_sof) begin
                            // Mid-frame SOF: report it and realign on this beat.
                            o_err_sof <= 1'b1;
                            o_sof     <= 1'b1;
                            o_count   <= '0;
                            idx_q     <= IDX_ONE;
                        end else begin
                            o_count <= idx_q;
                            idx_q   <= idx_q + IDX_ONE;
                            if (idx_q == IDX_LAST) begin
                                o_eof   <= 1'b1;
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end

`ifdef FE_BF2_SEQ_FLUSH_EN
                ST_FLUSH: begin
                    o_valid_dp <= 1'b1;
                    o_flush    <= 1'b1;
                    o_count    <= idx_q;
                    idx_q      <= idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                    // o_ready is low here, so any offered beat is lost.
                    if (i_valid) begin
                        o_err_sync <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    o_busy  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe_bf2_seq.sv
module tb_fe_bf2_seq;

    localparam int NFFT_LOG2 = 4;
    localparam int NPAIR     = 8;
    localparam int TMO       = 4;
`ifdef FE_BF2_SEQ_FLUSH_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_async_n = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic       o_ready, o_valid_dp, o_flush, o_sof, o_eof, o_busy, o_err_sof, o_err_sync;
    logic [2:0] o_count;

    fe_bf2_seq #(
        .NFFT_LOG2 (NFFT_LOG2),
        .TMO       (TMO)
    ) dut (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .o_ready     (o_ready),
        .o_valid_dp  (o_valid_dp),
        .o_flush     (o_flush),
        .o_count     (o_count),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_busy      (o_busy),
        .o_err_sof   (o_err_sof),
        .o_err_sync  (o_err_sync)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_acc = -1000;

    // Reference model: mode 0 idle, 1 in frame, 2 between frames, 3 flushing.
    int mode = 0;
    int pos  = 0;   // next beat position within frame or flush
    int idle = 0;   // idle cycles since last accepted beat while between frames
    bit e_valid, e_flush, e_sof, e_eof, e_err_sof, e_err_sync, e_busy;
    int e_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        mode = 0; pos = 0; idle = 0;
        e_valid = 0; e_flush = 0; e_sof = 0; e_eof = 0;
        e_err_sof = 0; e_err_sync = 0; e_busy = 0; e_cnt = 0;
    endtask

    task automatic model(input bit v, input bit s, input bit en);
        bit acc;
        acc = v && !(FE && mode == 3);
        if (acc) last_acc = cyc;
        e_valid = 0; e_flush = 0; e_sof = 0; e_eof = 0; e_err_sof = 0; e_err_sync = 0;
        case (mode)
            0, 2: begin
                if (acc) begin
                    idle = 0;
                    if (s && en) begin
                        mode = 1; pos = 1; e_valid = 1; e_sof = 1; e_cnt = 0;
                    end else if (!s) begin
                        e_err_sync = 1;
                    end
                end else if (FE && mode == 2) begin
                    idle = idle + 1;
                    if (idle == TMO) begin
                        mode = 3; pos = 0;
                    end
                end
            end
            1: begin
                if (acc) begin
                    e_valid = 1;
                    if (s) begin
                        e_err_sof = 1; e_sof = 1; e_cnt = 0; pos = 1;
                    end else begin
                        e_cnt = pos;
                        if (pos == NPAIR - 1) begin
                            e_eof = 1; mode = 2; idle = 0; pos = 0;
                        end else begin
                            pos = pos + 1;
                        end
                    end
                end
            end
            default: begin
                e_valid = 1; e_flush = 1; e_cnt = pos;
                pos = pos + 1;
                if (pos == NPAIR) begin
                    mode = 0; pos = 0;
                end
                if (v) e_err_sync = 1;
            end
        endcase
        e_busy = (mode != 0);
    endtask

    // One clock cycle: check last edge's outputs, then drive this cycle's inputs.
    task automatic step(input bit v, input bit s, input bit en);
        @(negedge clk);
        cyc++;
        chk("valid_dp", o_valid_dp, e_valid);
        chk("flush", o_flush, e_flush);
        chk("sof", o_sof, e_sof);
        chk("eof", o_eof, e_eof);
        chk("err_sof", o_err_sof, e_err_sof);
        chk("err_sync", o_err_sync, e_err_sync);
        chk("busy", o_busy, e_busy);
        chk("ready", o_ready, (FE && mode == 3) ? 0 : 1);
        if (e_valid) chk("count", o_count, e_cnt);
`ifdef FE_BF2_SEQ_FLUSH_EN
        // First flush beat must appear TMO+2 cycles after the last accepted beat.
        if (o_valid_dp && o_flush && o_count == 3'd0) chk("flush_lat", cyc - last_acc, TMO + 2);
`endif
        i_valid = v; i_sof = s; i_enable = en;
        model(v, s, en);
    endtask

    task automatic frame();
        for (int i = 0; i < NPAIR; i++) step(1'b1, i == 0, 1'b1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_dp"}, o_valid_dp, 0);
        chk({tag, "_flush"}, o_flush, 0);
        chk({tag, "_count"}, o_count, 0);
        chk({tag, "_sof"}, o_sof, 0);
        chk({tag, "_eof"}, o_eof, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_err_sof"}, o_err_sof, 0);
        chk({tag, "_err_sync"}, o_err_sync, 0);
        chk({tag, "_ready"}, o_ready, 1);
    endtask

    int  len;
    bit  act;

    initial begin
        model_reset();
        #1 rst_async_n = 1'b0;
        #3 check_reset_outputs("rst");
        @(negedge clk);
        rst_async_n = 1'b1;

        // Single frame then idle long enough for a complete flush.
        frame();
        gap(20);

        // Back-to-back frames, one flush afterwards.
        frame();
        frame();
        gap(20);

        // Early SOF at index 5 restarts the frame.
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < NPAIR - 1; i++) step(1'b1, 1'b0, 1'b1);
        gap(20);

        // Orphan beat in IDLE, then a beat offered during flush.
        step(1'b1, 1'b0, 1'b1);
        frame();
        gap(TMO + 2);
        step(1'b1, 1'b0, 1'b0);
        gap(20);

        // Gap boundary: TMO-1 idle cycles do not flush, TMO do.
        frame();
        gap(TMO - 1);
        frame();
        step(1'b1, 1'b1, 1'b0);   // SOF with enable low: silently dropped
        gap(TMO);
        gap(20);

        // Reset asserted during flush beat 3 (or mid-frame without flush).
        frame();
        gap(TMO + 4);
        #1 rst_async_n = 1'b0;
        #1 check_reset_outputs("rst_flush");
        model_reset();
        i_valid = 1'b0; i_sof = 1'b0; i_enable = 1'b0;
        @(negedge clk);
        rst_async_n = 1'b1;
        frame();
        gap(20);

        // Randomised bursts of activity and idle stretches.
        for (int k = 0; k < 300; k++) begin
            len = $urandom_range(1, 12);
            act = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < len; j++) begin
                if (act)
                    step($urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0,
                         $urandom_range(0, 7) != 0);
                else
                    step(1'b0, 1'b0, 1'b0);
            end
        end
        gap(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
